shift_reg_univ: RTL and testbench
=================================

Name: shift_reg_univ

Overview:
- Parametrised universal register: parallel load, shift, rotate and arithmetic shift, plus clear and set.
- Adds a multi-cycle "shift by N" operation with a start/busy/done handshake.
- Replaces the single-bit set/reset flip-flops in the sequential library wherever a multi-bit, mode-controlled storage element is needed.

Parameters:
- WIDTH, 8, register width in bits (minimum 2).
- RST_VAL, {WIDTH{1'b0}}, value loaded into q on reset.
- CNT_W, $clog2(WIDTH+1), width of the shamt input and the internal counter (derived; not overridden).

Ports:
- clk  input  1  clock; all synchronous activity occurs on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- set  input  1  synchronous, active-high; forces q to all ones.
- en  input  1  single-step enable for mode operations while IDLE.
- mode  input  3  operation select (encoding below).
- d  input  WIDTH  parallel load data.
- sin_r  input  1  serial input entering the LSB on shift-left.
- sin_l  input  1  serial input entering the MSB on logical shift-right.
- start  input  1  launch a multi-cycle operation of shamt steps.
- shamt  input  CNT_W  number of steps for a multi-cycle operation.
- q  output  WIDTH  register contents.
- sout_l  output  1  q[WIDTH-1], combinational.
- sout_r  output  1  q[0], combinational.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse in the DONE state.

Behaviour:
- Reset: rst low asynchronously forces q=RST_VAL, state=IDLE, cnt=0, busy=0, done=0, regardless of clk. Release is synchronous to the next rising edge.
- Mode encoding (op applied once per step):
  - 000 hold
  - 001 load d
  - 010 shift left: {q[WIDTH-2:0], sin_r}
  - 011 logical shift right: {sin_l, q[WIDTH-1:1]}
  - 100 rotate left
  - 101 rotate right
  - 110 arithmetic shift right (MSB replicated)
  - 111 clear to 0
- Priority at each rising edge, highest first: set > RUN/DONE sequencing > start (IDLE only) > en single step.
- set=1: q=all ones; state forced to IDLE; cnt cleared; done not pulsed. This aborts any in-flight operation.
- FSM states IDLE, RUN, DONE:
  - IDLE with start=1: latch mode into op_r and shamt into cnt; q unchanged on this edge. Next state is RUN if shamt!=0, else DONE.
  - IDLE with start=0 and en=1: apply mode to q once. Stay IDLE.
  - IDLE with start=0 and en=0: q holds.
  - RUN: each edge applies op_r once and decrements cnt. On the edge where cnt==1, apply the last step and go to DONE.
  - DONE: done=1 for exactly one cycle; q holds. Next edge goes to IDLE; start and en are ignored on that edge.
- Latency:
  - start sampled at edge E → shamt steps complete at edge E+shamt.
  - done is high in the cycle following edge E+shamt (E+1 for shamt=0).
  - busy is high from E+1 until edge E+shamt.
- While busy or done is high: start, en, mode, shamt, d are ignored. Serial inputs sin_l/sin_r are sampled live on each RUN step, not latched.
- shamt greater than WIDTH is legal: performs shamt steps. Rotates wrap modulo WIDTH; shifts saturate to fill-value patterns.
- start=1 held continuously: relaunches on each return to IDLE, i.e. every shamt+2 cycles.
- sout_l/sout_r always reflect current q, including during reset.
- No combinational path from any input to q, busy, or done.

Test Plan:
- rst pulsed low mid-RUN (q=0x3C, cnt=2) with no clock edge → q=0x00, busy=0, done=0 immediately. First edge after release with en=0 leaves q=0x00.
- en=1, mode=001, d=0xA5 → q=0xA5 after one edge. Then mode=010, sin_r=1 → q=0x4B. Then mode=011, sin_l=0 → q=0x25.
- q=0x81; start=1, mode=100, shamt=3 → busy=1 for 3 cycles, q steps 0x03, 0x06, 0x0C. done=1 for one cycle after the third step, then IDLE.
- q=0x80; start=1, mode=110, shamt=2 → q=0xC0 then 0xE0, done pulse. Repeat with mode=101, shamt=8 → q returns to 0xE0.
- During RUN (mode=010, shamt=5), pulse start with a different mode → ignored. set=1 on the second RUN cycle → q=0xFF, state IDLE, no done pulse.
- start with shamt=0, q=0x5A → busy stays 0, done=1 on the next cycle, q=0x5A unchanged. en=1 during DONE → no change.

Source files
------------

// File: rtl/shift_reg_univ.sv
// Universal shift register: parallel load, shift, rotate, arithmetic shift,
// clear and set, plus a multi-cycle "shift by N" with start/busy/done.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | single-step ops via en, or accept start (latch op and count)
// RUN   | apply latched op once per edge, count down to terminal 1
// DONE  | one-cycle done pulse, q holds, start/en ignored
module shift_reg_univ #(
  parameter int              WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
  parameter int              CNT_W   = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             set,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic             start,
  input  logic [CNT_W-1:0] shamt,
  output logic [WIDTH-1:0] q,
  output logic             sout_l,
  output logic             sout_r,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [2:0] M_HOLD = 3'b000;
  localparam logic [2:0] M_LOAD = 3'b001;
  localparam logic [2:0] M_SHL  = 3'b010;
  localparam logic [2:0] M_SHR  = 3'b011;
  localparam logic [2:0] M_ROL  = 3'b100;
  localparam logic [2:0] M_ROR  = 3'b101;
  localparam logic [2:0] M_ASR  = 3'b110;
  localparam logic [2:0] M_CLR  = 3'b111;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_q;

  logic [2:0]       w_op;
  logic [WIDTH-1:0] w_step_q;

  // In RUN the latched op drives the datapath; elsewhere the live mode does.
  assign w_op = (r_state == RUN) ? r_op : mode;

  // One step of the selected operation applied to the current contents.
  always_comb begin
    w_step_q = r_q;
    case (w_op)
      M_HOLD: w_step_q = r_q;
      M_LOAD: w_step_q = d;
      M_SHL:  w_step_q = {r_q[WIDTH-2:0], sin_r};
      M_SHR:  w_step_q = {sin_l, r_q[WIDTH-1:1]};
      M_ROL:  w_step_q = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
      M_ROR:  w_step_q = {r_q[0], r_q[WIDTH-1:1]};
      M_ASR:  w_step_q = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
      M_CLR:  w_step_q = {WIDTH{1'b0}};
      default: w_step_q = r_q;
    endcase
  end

  // Register contents and sequencing; set overrides everything but reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_q     <= RST_VAL;
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= M_HOLD;
    end else if (set) begin
      r_q     <= {WIDTH{1'b1}};
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_op    <= mode;
            r_cnt   <= shamt;
            r_state <= (shamt != '0) ? RUN : DONE;
          end else if (en) begin
            r_q <= w_step_q;
          end
        end
        RUN: begin
          r_q   <= w_step_q;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign q      = r_q;
  assign sout_l = r_q[WIDTH-1];
  assign sout_r = r_q[0];
  assign busy   = (r_state == RUN);
  assign done   = (r_state == DONE);

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ (WIDTH=8). Stimulus pushes the expected
// post-edge state into a queue; a monitor pops and compares mid-cycle.
module tb_shift_reg_univ;

  localparam int W = 8;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          set;
  logic          en;
  logic [2:0]    mode;
  logic [W-1:0]  d;
  logic          sin_r;
  logic          sin_l;
  logic          start;
  logic [CW-1:0] shamt;
  logic [W-1:0]  q;
  logic          sout_l;
  logic          sout_r;
  logic          busy;
  logic          done;

  typedef struct {
    logic [W-1:0] q;
    logic         busy;
    logic         done;
    string        tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  shift_reg_univ #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst    (rst),
    .set    (set),
    .en     (en),
    .mode   (mode),
    .d      (d),
    .sin_r  (sin_r),
    .sin_l  (sin_l),
    .start  (start),
    .shamt  (shamt),
    .q      (q),
    .sout_l (sout_l),
    .sout_r (sout_r),
    .busy   (busy),
    .done   (done)
  );

  always #5 clk = ~clk;

  // Monitor: one expectation per sample point, away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk or negedge rst);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_vec++;
        if (q !== e.q || busy !== e.busy || done !== e.done ||
            sout_l !== e.q[W-1] || sout_r !== e.q[0]) begin
          n_err++;
          $display("FAIL %s: got q=%h busy=%b done=%b sl=%b sr=%b, want q=%h busy=%b done=%b sl=%b sr=%b",
                   e.tag, q, busy, done, sout_l, sout_r,
                   e.q, e.busy, e.done, e.q[W-1], e.q[0]);
        end
      end
    end
  end

  task automatic push(input logic [W-1:0] eq, input logic eb, input logic ed,
                      input string tag);
    exp_t e;
    e.q = eq; e.busy = eb; e.done = ed; e.tag = tag;
    exp_q.push_back(e);
  endtask

  // Let one rising edge happen with the current inputs, then record its result.
  task automatic cyc(input logic [W-1:0] eq, input logic eb, input logic ed,
                     input string tag);
    @(posedge clk);
    #1;
    push(eq, eb, ed, tag);
  endtask

  logic [W-1:0] ror_seq [8] = '{8'h70, 8'h38, 8'h1C, 8'h0E, 8'h07, 8'h83, 8'hC1, 8'hE0};

  initial begin
    rst = 1'b0; set = 1'b0; en = 1'b0; mode = 3'b000; d = '0;
    sin_r = 1'b0; sin_l = 1'b0; start = 1'b0; shamt = '0;

    cyc(8'h00, 1'b0, 1'b0, "reset");
    rst = 1'b1;

    // single-step ops
    en = 1'b1; mode = 3'b001; d = 8'hA5;
    cyc(8'hA5, 1'b0, 1'b0, "load_a5");
    mode = 3'b010; sin_r = 1'b1;
    cyc(8'h4B, 1'b0, 1'b0, "shl");
    mode = 3'b011; sin_l = 1'b0;
    cyc(8'h25, 1'b0, 1'b0, "shr");
    sin_r = 1'b0;

    // rotate left by 3
    mode = 3'b001; d = 8'h81;
    cyc(8'h81, 1'b0, 1'b0, "load_81");
    en = 1'b0; start = 1'b1; mode = 3'b100; shamt = CW'(3);
    cyc(8'h81, 1'b1, 1'b0, "rol_start");
    start = 1'b0; mode = 3'b000;
    cyc(8'h03, 1'b1, 1'b0, "rol_s1");
    cyc(8'h06, 1'b1, 1'b0, "rol_s2");
    cyc(8'h0C, 1'b0, 1'b1, "rol_done");
    cyc(8'h0C, 1'b0, 1'b0, "rol_idle");

    // arithmetic shift right by 2
    en = 1'b1; mode = 3'b001; d = 8'h80;
    cyc(8'h80, 1'b0, 1'b0, "load_80");
    en = 1'b0; start = 1'b1; mode = 3'b110; shamt = CW'(2);
    cyc(8'h80, 1'b1, 1'b0, "asr_start");
    start = 1'b0;
    cyc(8'hC0, 1'b1, 1'b0, "asr_s1");
    cyc(8'hE0, 1'b0, 1'b1, "asr_done");
    cyc(8'hE0, 1'b0, 1'b0, "asr_idle");

    // rotate right by WIDTH wraps back
    start = 1'b1; mode = 3'b101; shamt = CW'(8);
    cyc(8'hE0, 1'b1, 1'b0, "ror_start");
    start = 1'b0; mode = 3'b000;
    for (int i = 0; i < 8; i++)
      cyc(ror_seq[i], (i < 7), (i == 7), $sformatf("ror_s%0d", i + 1));
    cyc(8'hE0, 1'b0, 1'b0, "ror_idle");

    // start ignored mid-run, set aborts without done
    start = 1'b1; mode = 3'b010; shamt = CW'(5); sin_r = 1'b0;
    cyc(8'hE0, 1'b1, 1'b0, "abort_start");
    start = 1'b1; mode = 3'b111; shamt = CW'(1);
    cyc(8'hC0, 1'b1, 1'b0, "restart_ignored");
    start = 1'b0; mode = 3'b000; set = 1'b1;
    cyc(8'hFF, 1'b0, 1'b0, "set_abort");
    set = 1'b0;
    cyc(8'hFF, 1'b0, 1'b0, "no_done_after_set");

    // zero-length operation
    en = 1'b1; mode = 3'b001; d = 8'h5A;
    cyc(8'h5A, 1'b0, 1'b0, "load_5a");
    en = 1'b0; start = 1'b1; mode = 3'b010; shamt = '0;
    cyc(8'h5A, 1'b0, 1'b1, "zero_done");
    start = 1'b0; en = 1'b1; mode = 3'b111;
    cyc(8'h5A, 1'b0, 1'b0, "en_ignored_in_done");
    en = 1'b0;
    cyc(8'h5A, 1'b0, 1'b0, "zero_idle");

    // asynchronous reset mid-run
    en = 1'b1; mode = 3'b001; d = 8'h3C;
    cyc(8'h3C, 1'b0, 1'b0, "load_3c");
    en = 1'b0; start = 1'b1; mode = 3'b000; shamt = CW'(4);
    cyc(8'h3C, 1'b1, 1'b0, "hold_start");
    start = 1'b0;
    cyc(8'h3C, 1'b1, 1'b0, "hold_s1");
    cyc(8'h3C, 1'b1, 1'b0, "hold_s2");
    @(negedge clk);
    #3;
    push(8'h00, 1'b0, 1'b0, "async_reset");
    rst = 1'b0;
    #1;
    rst = 1'b1;
    cyc(8'h00, 1'b0, 1'b0, "after_release");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #2;
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
